svc_uart_rx: RTL and testbench

- UART receiver that consumes the serial line driven by the SoC's `uart_tx` and sits directly downstream of it.
- Synchronises the line, finds start bits, samples 8N1 frames at mid-bit and presents each byte on a valid/ready interface.
- A sim console monitor, or a loopback/command path on hardware, reads that interface.
- Flags framing errors and overruns as single-cycle pulses.

---
 rtl/svc_uart_pkg.sv | 8 +
 rtl/svc_sync_bit.sv | 17 +
 rtl/svc_uart_rx.sv | 107 ++++++++++
 tb/tb_svc_uart_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/svc_uart_pkg.sv
// svc_uart_pkg: shared receiver state type, baud divisor helper and frame width
package svc_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int uart_div(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000 + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/svc_sync_bit.sv
// svc_sync_bit: STAGES-deep flop synchroniser for one asynchronous bit
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised output)
module svc_sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= {STAGES{RESET_VAL}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/svc_uart_rx.sv
// svc_uart_rx: 8N1 UART receiver with mid-bit sampling and a valid/ready holding register
// Ports: clk, rst_n (async active-low), urx (serial line, idles high),
//        rx_valid/rx_data/rx_ready (byte handshake), rx_busy (not idle),
//        rx_frame_err / rx_overrun (single-cycle error pulses)
module svc_uart_rx
  import svc_uart_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 25,
  parameter int BAUD_RATE      = 115_200,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);
  localparam int DIV = uart_div(CLOCK_FREQ_MHZ, BAUD_RATE);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);
  uart_rx_state_t state;
  logic s, s_prev;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  svc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (urx),
    .q    (s)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      s_prev       <= 1'b1;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_busy      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      s_prev       <= s;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE:
          if (s_prev && !s) begin
            cnt     <= HALF_M1;
            state   <= START;
            rx_busy <= 1'b1;
          end
        START:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            cnt     <= DIV_M1;
            bit_idx <= '0;
            state   <= DATA;
          end
        DATA:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg   <= {s, shreg[UART_DATA_BITS-1:1]};
            cnt     <= DIV_M1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end
        STOP:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            // a same-cycle read frees the holding register for the new byte
            if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else rx_overrun <= 1'b1;
          end else begin
            rx_frame_err <= 1'b1;
            state        <= WAIT_HIGH;
          end
        // a held-low line (break) must return high before a new start is accepted
        WAIT_HIGH:
          if (s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_svc_uart_rx.sv
// tb_svc_uart_rx: directed bench for svc_uart_rx at DIV=8, HALF=4
module tb_svc_uart_rx;
  logic clk = 1'b0, rst_n = 1'b0, urx = 1'b1, rx_ready = 1'b0;
  logic rx_valid, rx_busy, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;
  int cyc = 0, errors = 0, checks = 0;
  int fe_n = 0, ov_n = 0, fe_t = 0, ov_t = 0, vh_n = 0;
  logic v_prev = 1'b0;
  logic [7:0] vq[$];
  int vt[$];

  svc_uart_rx #(.CLOCK_FREQ_MHZ(1), .BAUD_RATE(125_000), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .urx         (urx),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !v_prev) begin
      vq.push_back(rx_data);
      vt.push_back(cyc);
    end
    if (rx_valid) vh_n++;
    if (rx_frame_err) begin
      fe_n++;
      fe_t = cyc;
    end
    if (rx_overrun) begin
      ov_n++;
      ov_t = cyc;
    end
    v_prev = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    urx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    hold(1'b0, 8);
    for (int i = 0; i < 8; i++) hold(b[i], 8);
    hold(stop, 8);
  endtask

  initial begin
    int t0, t1, nv, nf, no, vh;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    rst_n = 1'b1;
    hold(1'b1, 4);

    rx_ready = 1'b1;
    nv = vq.size(); nf = fe_n; no = ov_n; vh = vh_n;
    send(8'h55, 1'b1, t0);
    hold(1'b1, 4);
    check("s1_count", vq.size() - nv, 1);
    check("s1_data", vq[nv], 8'h55);
    check("s1_latency", vt[nv] - t0, 79);
    check("s1_width", vh_n - vh, 1);
    check("s1_ferr", fe_n - nf, 0);
    check("s1_ovr", ov_n - no, 0);

    rx_ready = 1'b0;
    nv = vq.size(); no = ov_n;
    send(8'hA3, 1'b1, t0);
    hold(1'b1, 2);
    send(8'h0F, 1'b1, t1);
    hold(1'b1, 4);
    check("s2_count", vq.size() - nv, 1);
    check("s2_first", vq[nv], 8'hA3);
    check("s2_held_valid", rx_valid, 1);
    check("s2_held_data", rx_data, 8'hA3);
    check("s2_ovr_count", ov_n - no, 1);
    check("s2_ovr_time", ov_t - t1, 79);
    rx_ready = 1'b1;
    @(negedge clk);
    check("s2_hs_valid", rx_valid, 1);
    @(posedge clk);
    #1;
    check("s2_valid_drop", rx_valid, 0);

    nv = vq.size(); nf = fe_n;
    urx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    urx = 1'b1;
    @(negedge clk);
    check("s3_busy_start", rx_busy, 1);
    repeat (4) @(negedge clk);
    check("s3_busy_fall", rx_busy, 0);
    @(posedge clk);
    #1;
    hold(1'b1, 16);
    check("s3_no_valid", vq.size() - nv, 0);
    check("s3_no_ferr", fe_n - nf, 0);

    nv = vq.size(); nf = fe_n;
    send(8'h81, 1'b0, t0);
    hold(1'b0, 40);
    check("s4_wait_busy", rx_busy, 1);
    check("s4_ferr_count", fe_n - nf, 1);
    check("s4_ferr_time", fe_t - t0, 79);
    hold(1'b1, 16);
    check("s4_idle", rx_busy, 0);
    send(8'h42, 1'b1, t1);
    hold(1'b1, 4);
    check("s4_count", vq.size() - nv, 1);
    check("s4_data", vq[nv], 8'h42);
    check("s4_latency", vt[nv] - t1, 79);
    check("s4_ferr_once", fe_n - nf, 1);

    nv = vq.size();
    send(8'h11, 1'b1, t0);
    send(8'h22, 1'b1, t1);
    hold(1'b1, 4);
    check("s5_count", vq.size() - nv, 2);
    check("s5_data0", vq[nv], 8'h11);
    check("s5_data1", vq[nv+1], 8'h22);
    check("s5_latency", vt[nv] - t0, 79);
    check("s5_spacing", vt[nv+1] - vt[nv], 80);
    check("s5_latency1", vt[nv+1] - t1, 79);

    nv = vq.size(); nf = fe_n; no = ov_n;
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    check("s6_busy_pre", rx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("s6_busy", rx_busy, 0);
    check("s6_valid", rx_valid, 0);
    check("s6_data", rx_data, 0);
    check("s6_ferr", rx_frame_err, 0);
    check("s6_ovr", rx_overrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 16);
    send(8'hC4, 1'b1, t1);
    hold(1'b1, 4);
    check("s6_count", vq.size() - nv, 1);
    check("s6_data_c4", vq[nv], 8'hC4);
    check("s6_latency", vt[nv] - t1, 79);
    check("s6_no_ferr", fe_n - nf, 0);
    check("s6_no_ovr", ov_n - no, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
